// File: rtl/vga_pkg.sv
// Shared frame-buffer geometry, pixel format and VRAM arbitration types.
// Used by the VRAM arbiter, the scan timing logic and the pixel generators.
package vga_pkg;

  localparam int FB_ADDR_W = 15;
  localparam int FB_DATA_W = 12;
  localparam int FB_H      = 200;
  localparam int FB_V      = 150;

  localparam int WBUF_DEPTH_DEF = 4;
  localparam int STARVE_MAX_DEF = 1024;

  // 4:4:4 RGB pixel as stored in the frame buffer.
  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } pixel_t;

  // Owner of the single RAM port for the current cycle.
  typedef enum logic [1:0] {
    GNT_IDLE,
    GNT_READ,
    GNT_WRITE
  } grant_e;

endpackage

// File: rtl/vram_wbuf_fifo.sv
// Synchronous write buffer for the VRAM arbiter: power-of-two depth,
// wrapping pointers, registered occupancy count, synchronous active-low reset.
module vram_wbuf_fifo
  import vga_pkg::*;
#(
  parameter int DEPTH = WBUF_DEPTH_DEF,
  parameter int WIDTH = FB_ADDR_W + FB_DATA_W
) (
  input  logic                   pclk,
  input  logic                   rstn,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (PTR_W + 1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge pclk) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: the storage array has no reset; an entry is only ever read after it
  // was written, and a reset-free array can map onto LUT RAM.
  always_ff @(posedge pclk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/vram_arbiter.sv
// Single-port frame-buffer arbiter: display reads always win, writes drain from
// a small FIFO in read-free cycles. Define VRAM_ARB_STATS_EN for stat counters.
module vram_arbiter
  import vga_pkg::*;
#(
  parameter int ADDR_W     = FB_ADDR_W,
  parameter int DATA_W     = FB_DATA_W,
  parameter int WBUF_DEPTH = WBUF_DEPTH_DEF,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic              pclk,
  input  logic              rstn,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wbuf_empty,
  output logic              starve_err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef VRAM_ARB_STATS_EN
  ,
  output logic [31:0]       stat_wr_cnt,
  output logic [31:0]       stat_stall_cnt
`endif
);

  localparam int CNT_W = $clog2(WBUF_DEPTH) + 1;
  localparam int SC_W  = $clog2(STARVE_MAX);

  grant_e                    grant;
  logic                      push;
  logic                      pop;
  logic                      f_full;
  logic                      f_empty;
  logic [CNT_W-1:0]          f_count;
  logic [ADDR_W+DATA_W-1:0]  f_dout;
  logic [ADDR_W-1:0]         head_addr;
  logic [DATA_W-1:0]         head_data;
  logic [ADDR_W-1:0]         last_addr;
  logic [DATA_W-1:0]         last_wdata;
  logic [SC_W-1:0]           starve_cnt;

  vram_wbuf_fifo #(
    .DEPTH (WBUF_DEPTH),
    .WIDTH (ADDR_W + DATA_W)
  ) u_wbuf (
    .pclk  (pclk),
    .rstn  (rstn),
    .push  (push),
    .pop   (pop),
    .din   ({wr_addr, wr_data}),
    .dout  (f_dout),
    .full  (f_full),
    .empty (f_empty),
    .count (f_count)
  );

  assign {head_addr, head_data} = f_dout;
  assign wr_ready   = rstn && !f_full;
  assign push       = wr_valid && wr_ready;
  assign pop        = (grant == GNT_WRITE);
  assign wbuf_empty = (f_count == '0);
  assign rd_data    = mem_rdata;

  // Writes are held off while in reset so a reset mid-drain cannot touch RAM.
  always_comb begin
    grant = GNT_IDLE;
    if (rd_req)                grant = GNT_READ;
    else if (rstn && !f_empty) grant = GNT_WRITE;
  end

  // NOTE: every output gets a default first so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = last_addr;
    mem_wdata = last_wdata;
    case (grant)
      GNT_READ: begin
        mem_en   = 1'b1;
        mem_addr = rd_addr;
      end
      GNT_WRITE: begin
        mem_en    = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = head_addr;
        mem_wdata = head_data;
      end
      default: ;
    endcase
  end

  // Starve counter saturates at STARVE_MAX-1; the next un-drained cycle sets the flag.
  always_ff @(posedge pclk) begin
    if (!rstn) begin
      rd_valid   <= 1'b0;
      last_addr  <= '0;
      last_wdata <= '0;
      starve_cnt <= '0;
      starve_err <= 1'b0;
    end else begin
      rd_valid <= rd_req;
      if (mem_en) last_addr  <= mem_addr;
      if (mem_we) last_wdata <= mem_wdata;
      if (pop || f_empty) begin
        starve_cnt <= '0;
      end else if (starve_cnt == SC_W'(STARVE_MAX - 1)) begin
        starve_err <= 1'b1;
      end else begin
        starve_cnt <= starve_cnt + 1'b1;
      end
    end
  end

`ifdef VRAM_ARB_STATS_EN
  always_ff @(posedge pclk) begin
    if (!rstn) begin
      stat_wr_cnt    <= '0;
      stat_stall_cnt <= '0;
    end else begin
      if (mem_we)                stat_wr_cnt    <= stat_wr_cnt + 32'd1;
      if (wr_valid && !wr_ready) stat_stall_cnt <= stat_stall_cnt + 32'd1;
    end
  end
`endif

endmodule
